// File: rtl/mem_stage_master.sv
// rtl/mem_stage_master.sv - MEM-stage initiator for the data memory with wait states and address checks
module mem_stage_master #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] val_rm,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        addr_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] address,
  output logic [31:0] data,
  input  logic [31:0] mem_result
);

  // Highest legal word address; computed once so the compare never wraps at run time.
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH) - 32'd4;
  localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_we, op_we_nxt;
  logic [31:0] lat_addr, lat_addr_nxt;
  logic [31:0] lat_data, lat_data_nxt;
  logic [31:0] read_data_nxt;
  logic        addr_err_nxt;
  logic        req;
  logic        legal;

  assign req   = mem_r_en | mem_w_en;
  assign legal = (mem_r_en ^ mem_w_en) &&
                 (alu_res >= BASE_ADDR) && (alu_res <= LAST_ADDR) &&
                 (alu_res[1:0] == 2'b00);

  // Memory side always sees the latched access; strobes only in BUSY and never while in reset.
  assign address   = lat_addr;
  assign data      = lat_data;
  assign mem_read  = (state == BUSY) && !op_we && !rst;
  assign mem_write = (state == BUSY) && op_we && (cnt == 4'd0) && !rst;

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_we     <= 1'b0;
      lat_addr  <= 32'd0;
      lat_data  <= 32'd0;
      read_data <= 32'd0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_we     <= op_we_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_data  <= lat_data_nxt;
      read_data <= read_data_nxt;
      addr_err  <= addr_err_nxt;
    end
  end

  // Next-state logic, request latching, wait countdown and pipeline freeze.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    op_we_nxt     = op_we;
    lat_addr_nxt  = lat_addr;
    lat_data_nxt  = lat_data;
    read_data_nxt = read_data;
    addr_err_nxt  = addr_err;
    ready         = 1'b0;
    case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          if (legal) begin
            op_we_nxt    = mem_w_en;
            lat_addr_nxt = alu_res;
            lat_data_nxt = val_rm;
            cnt_nxt      = CNT_INIT;
            state_nxt    = BUSY;
          end else begin
            addr_err_nxt  = 1'b1;
            read_data_nxt = 32'd0;
            state_nxt     = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          if (!op_we) begin
            read_data_nxt = mem_result;
          end
          addr_err_nxt = 1'b0;
          state_nxt    = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        // Pipeline advances on this edge; a still-present request is the one just finished.
        ready        = 1'b1;
        addr_err_nxt = 1'b0;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage_master.sv
// tb/tb_mem_stage_master.sv - randomized self-checking bench for mem_stage_master
module tb_mem_stage_master;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int          DEP  = 64;
  localparam int          W    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic        ready;
  logic [31:0] read_data;
  logic        addr_err;
  logic        mem_read, mem_write;
  logic [31:0] address, data;
  logic [31:0] mem_result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        init_mem;
  logic [5:0]  midx;
  logic        in_win;

  logic [31:0] exp_rd, exp_addr, exp_data;

  mem_stage_master #(.BASE_ADDR(BASE), .DEPTH(DEP), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .ready(ready), .read_data(read_data),
    .addr_err(addr_err), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data(data), .mem_result(mem_result)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on rising edge.
  assign midx       = 6'((address - BASE) >> 2);
  assign in_win     = (address >= BASE) && (address <= BASE + 32'd252);
  assign mem_result = in_win ? mem[midx] : 32'h0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_write && in_win) begin
      mem[midx] <= data;
    end
  end

  task automatic set_inputs(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_r_en = r;
    mem_w_en = w;
    alu_res  = a;
    val_rm   = d;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One pipeline access from the request cycle to the completion cycle, checked against the model.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
    longint la;
    bit     legal, done;
    int     stall, rd, wr, first_rd, wr_cyc, bad_bus, err_mid, idx;
    int     exp_stall, exp_rdn, exp_wrn, exp_first, exp_wcyc;
    la    = longint'(a);
    legal = (r != w) && (la >= longint'(BASE)) && (la <= longint'(BASE) + 4 * DEP - 4) && (a[1:0] == 2'b00);
    idx   = int'((la - longint'(BASE)) / 4);
    @(negedge clk);
    set_inputs(r, w, a, d);
    done = 0; stall = 0; rd = 0; wr = 0; first_rd = -1; wr_cyc = -1; bad_bus = 0; err_mid = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (ready) begin
        done = 1;
      end else begin
        stall++;
        if (mem_read) begin
          rd++;
          if (first_rd < 0) first_rd = c;
          if (address !== a) bad_bus++;
        end
        if (mem_write) begin
          wr++;
          wr_cyc = c;
          if (address !== a || data !== d) bad_bus++;
        end
        if (addr_err) err_mid++;
        @(negedge clk);
      end
    end
    if (legal) begin
      exp_addr = a;
      exp_data = d;
      if (w) ref_mem[idx] = d;
      else   exp_rd = ref_mem[idx];
    end else begin
      exp_rd = 32'h0;
    end
    exp_stall = legal ? W + 1 : 1;
    exp_rdn   = (legal && r) ? W : 0;
    exp_wrn   = (legal && w) ? 1 : 0;
    exp_first = (legal && r) ? 1 : -1;
    exp_wcyc  = (legal && w) ? W : -1;

    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s timeout: ready got %0b want 1", tag, ready); end
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("FAIL %s stall: got %0d want %0d", tag, stall, exp_stall); end
    n_checks++;
    if (rd !== exp_rdn || first_rd !== exp_first) begin
      n_fail++; $display("FAIL %s mem_read: got %0d cycles from %0d want %0d from %0d", tag, rd, first_rd, exp_rdn, exp_first);
    end
    n_checks++;
    if (wr !== exp_wrn || wr_cyc !== exp_wcyc) begin
      n_fail++; $display("FAIL %s mem_write: got %0d pulses at %0d want %0d at %0d", tag, wr, wr_cyc, exp_wrn, exp_wcyc);
    end
    n_checks++;
    if (bad_bus !== 0) begin n_fail++; $display("FAIL %s bus: got %0d bad strobe cycles want 0", tag, bad_bus); end
    n_checks++;
    if (err_mid !== 0) begin n_fail++; $display("FAIL %s addr_err_stall: got %0d cycles want 0", tag, err_mid); end
    n_checks++;
    if (addr_err !== !legal) begin n_fail++; $display("FAIL %s addr_err: got %0b want %0b", tag, addr_err, !legal); end
    n_checks++;
    if (read_data !== exp_rd) begin n_fail++; $display("FAIL %s read_data: got %h want %h", tag, read_data, exp_rd); end
    n_checks++;
    if (address !== exp_addr || data !== exp_data) begin
      n_fail++; $display("FAIL %s latched: got %h/%h want %h/%h", tag, address, data, exp_addr, exp_data);
    end
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL %s done_strobe: got %0b%0b want 00", tag, mem_read, mem_write);
    end
    if (legal && w) begin
      n_checks++;
      if (mem[idx] !== d) begin n_fail++; $display("FAIL %s mem_word: got %h want %h", tag, mem[idx], d); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_mem = 1'b1;
    set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    exp_rd = 32'h0; exp_addr = 32'h0; exp_data = 32'h0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || read_data !== 32'h0 || addr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy=%0b rd=%h err=%0b want 1/0/0", ready, read_data, addr_err);
    end
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || address !== 32'h0 || data !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got %0b%0b %h %h want 00 0 0", mem_read, mem_write, address, data);
    end
  endtask

  task automatic test_store_load();
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "store_1024");
    idle_cycle();
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, "load_1024");
    idle_cycle();
  endtask

  task automatic test_last_word();
    run_access(1'b0, 1'b1, 32'd1276, 32'h12345678, "store_1276");
    run_access(1'b1, 1'b0, 32'd1276, 32'h0, "load_1276");
    run_access(1'b1, 1'b0, 32'd1280, 32'h0, "load_1280");
    idle_cycle();
  endtask

  task automatic test_illegal();
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, "reload_1024");
    run_access(1'b1, 1'b0, 32'd1026, 32'h0, "misaligned");
    run_access(1'b1, 1'b1, 32'd1024, 32'h55AA55AA, "both_en");
    run_access(1'b1, 1'b0, 32'd1020, 32'h0, "below_base");
    run_access(1'b0, 1'b1, 32'hFFFFFFFC, 32'h11111111, "top_wrap");
    run_access(1'b0, 1'b1, 32'd1280, 32'h22222222, "store_1280");
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'd1028, 32'hA5A50001, "b2b_store_1028");
    run_access(1'b0, 1'b1, 32'd1032, 32'hA5A50002, "b2b_store_1032");
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, "b2b_load_1028");
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, "b2b_load_1032");
    idle_cycle();
  endtask

  // Store to 1040, reset asserted in cycle rst_cyc of the access (cycle 0 = request cycle).
  task automatic test_reset_abort(input int rst_cyc);
    logic [31:0] prev;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, "pre_abort_load");
    prev = ref_mem[4];
    @(negedge clk);
    set_inputs(1'b0, 1'b1, 32'd1040, $urandom | 32'h1);
    for (int c = 0; c < rst_cyc; c++) @(negedge clk);
    rst = 1'b1;
    set_inputs(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL abort%0d_wr_gate: got %0b want 0", rst_cyc, mem_write); end
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0; exp_addr = 32'h0; exp_data = 32'h0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || read_data !== 32'h0 || addr_err !== 1'b0 || address !== 32'h0) begin
      n_fail++; $display("FAIL abort%0d_state: got rdy=%0b rd=%h err=%0b a=%h want 1/0/0/0",
                         rst_cyc, ready, read_data, addr_err, address);
    end
    n_checks++;
    if (mem[4] !== prev) begin n_fail++; $display("FAIL abort%0d_mem: got %h want %h", rst_cyc, mem[4], prev); end
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, "post_abort_load");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        r, w;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 32'(4 * $urandom_range(0, 63));
        3:       a = BASE + 32'($urandom_range(0, 255));
        4: begin
          case ($urandom_range(0, 3))
            0:       a = BASE - 32'd4;
            1:       a = BASE + 32'd256;
            2:       a = 32'hFFFFFFFC;
            default: a = 32'h0;
          endcase
        end
        default: a = $urandom;
      endcase
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      run_access(r, w, a, $urandom, "random");
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_last_word();
    test_illegal();
    test_back_to_back();
    test_reset_abort(1);
    test_reset_abort(2);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
